mux_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 16:1 enabled bit-mux (4 groups x 4 lanes, group select plus lane select plus output enable) between 16 requesting channels.
- Grants one channel at a time and drives the mux select and enable for a burst of N cycles.
- Shifts the mux output into a 16-bit word and delivers that word over a valid/ready handshake.
- Sits between the request sources and the combinational mux datapath; the mux itself is external.

---
 rtl/mux_rr_sched_if.sv | 28 ++
 rtl/mux_rr_sched.sv | 101 ++++++++++
 tb/tb_mux_rr_sched.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_sched_if.sv
// Bundle of request, mux-control and word-delivery signals of the round-robin mux scheduler.
// master = scheduler side, slave = request sources, mux datapath and word consumer.
interface mux_rr_sched_if #(
  parameter int N_CH  = 16,
  parameter int LEN_W = 4
);
  logic [N_CH-1:0]  req;
  logic [LEN_W-1:0] burst_len;
  logic [3:0]       mux_sel;
  logic             mux_en;
  logic             mux_out;
  logic [N_CH-1:0]  grant;
  logic             busy;
  logic             word_valid;
  logic             word_ready;
  logic [15:0]      word_data;
  logic [3:0]       word_ch;

  modport master (
    input  req, burst_len, mux_out, word_ready,
    output mux_sel, mux_en, grant, busy, word_valid, word_data, word_ch
  );

  modport slave (
    output req, burst_len, mux_out, word_ready,
    input  mux_sel, mux_en, grant, busy, word_valid, word_data, word_ch
  );
endinterface

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler driving an external 16:1 enabled bit-mux; shifts a burst of
// mux samples into a 16-bit word and delivers it over a valid/ready handshake.
module mux_rr_sched #(
  parameter int N_CH  = 16,
  parameter int LEN_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  mux_rr_sched_if.master      bus,
  output logic [1:0]          dbg_state
);
  // Handshake: word_valid stays high with word_data/word_ch stable until an edge
  // sees word_ready=1; ready while valid is low is ignored.
  typedef enum logic [1:0] {IDLE = 2'd0, SAMPLE = 2'd1, DELIVER = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [3:0]       last_q, last_d;
  logic [3:0]       ch_q, ch_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W:0]   len_q, len_d;
  logic [15:0]      word_q, word_d;

  logic [3:0] pick_ch;
  logic       pick_hit;
  logic [3:0] idx;

  // First requester scanning last+1, last+2, ... with wrap.
  always_comb begin
    pick_ch  = '0;
    pick_hit = 1'b0;
    idx      = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = last_q + 4'(i);
      if (!pick_hit && bus.req[idx]) begin
        pick_hit = 1'b1;
        pick_ch  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          ch_d    = pick_ch;
          cnt_d   = '0;
          len_d   = (bus.burst_len == '0) ? (LEN_W+1)'(1 << LEN_W)
                                          : {1'b0, bus.burst_len};
          word_d  = '0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        word_d[cnt_q] = bus.mux_out;
        cnt_d         = cnt_q + LEN_W'(1);
        if ({1'b0, cnt_q} == len_q - (LEN_W+1)'(1)) state_d = DELIVER;
      end
      DELIVER: begin
        if (bus.word_ready) begin
          last_d  = ch_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 4'd15;
      ch_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      word_q  <= word_d;
    end
  end

  // ch_q holds the last granted channel through IDLE, so mux_sel never glitches to 0.
  assign bus.mux_sel    = ch_q;
  assign bus.mux_en     = (state_q == SAMPLE);
  assign bus.grant      = (state_q != IDLE) ? (N_CH'(1) << ch_q) : '0;
  assign bus.busy       = (state_q != IDLE);
  assign bus.word_valid = (state_q == DELIVER);
  assign bus.word_data  = word_q;
  assign bus.word_ch    = ch_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_mux_rr_sched.sv
// Randomised bench for mux_rr_sched: a transaction-level model predicts every output
// each cycle, and directed scenarios pin the model with hand-computed values.
module tb_mux_rr_sched;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  mux_rr_sched_if #(.N_CH(16), .LEN_W(4)) bus ();

  mux_rr_sched #(.N_CH(16), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: mode 0 waiting, 1 collecting samples, 2 offering the word
  int          m_mode;
  int          m_last;
  int          m_ch;
  int          m_len;
  logic [15:0] m_word;
  logic        m_bits[$];
  bit          model_ok = 1'b0;
  logic [3:0]  order_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_last = 15; m_ch = 0; m_len = 0; m_word = '0;
      m_bits.delete();
    end else begin
      case (m_mode)
        0: if (bus.req != 16'h0) begin
             for (int k = 1; k <= 16; k++) begin
               if (bus.req[(m_last + k) % 16]) begin
                 m_ch = (m_last + k) % 16;
                 break;
               end
             end
             m_len  = (bus.burst_len == 4'd0) ? 16 : int'(bus.burst_len);
             m_word = '0;
             m_bits.delete();
             m_mode = 1;
           end
        1: begin
             m_bits.push_back(bus.mux_out);
             if (bus.mux_out) m_word = m_word | (16'h1 << (m_bits.size() - 1));
             if (m_bits.size() == m_len) m_mode = 2;
           end
        default: if (bus.word_ready) begin
             m_last = m_ch;
             m_mode = 0;
           end
      endcase
    end
    model_ok = 1'b1;
  end

  always @(posedge clk)
    if (!rst && bus.word_valid && bus.word_ready) order_q.push_back(bus.word_ch);

  // scoreboard compare every cycle
  always @(negedge clk) begin
    if (model_ok) begin
      chk("mux_sel",    32'(bus.mux_sel),    32'(m_ch));
      chk("mux_en",     32'(bus.mux_en),     32'(m_mode == 1));
      chk("grant",      32'(bus.grant),      (m_mode != 0) ? (32'h1 << m_ch) : 32'h0);
      chk("busy",       32'(bus.busy),       32'(m_mode != 0));
      chk("word_valid", 32'(bus.word_valid), 32'(m_mode == 2));
      chk("word_data",  32'(bus.word_data),  32'(m_word));
      chk("word_ch",    32'(bus.word_ch),    32'(m_ch));
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input bit rand_mux, output int en_cycles);
    bit seen = 1'b0;
    en_cycles = 0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (rand_mux) bus.mux_out = 1'($urandom_range(0, 1));
      if (bus.mux_en) en_cycles++;
      if (bus.word_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("valid_timeout", 32'(seen), 32'h1);
  endtask

  initial begin
    int en;
    bit got4;
    rst = 1'b1;
    bus.req = '0; bus.burst_len = '0; bus.mux_out = 1'b0; bus.word_ready = 1'b0;
    step();
    step();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    chk("rst_valid", 32'(bus.word_valid), 32'h0);
    chk("rst_data",  32'(bus.word_data), 32'h0);
    chk("rst_sel",   32'(bus.mux_sel), 32'h0);
    rst = 1'b0;

    // single burst of 4 with pattern 1,0,1,1
    step();
    bus.req = 16'h0001; bus.burst_len = 4'd4;
    step();
    bus.req = '0; bus.mux_out = 1'b1;
    chk("t1_grant", 32'(bus.grant), 32'h0001);
    chk("t1_en",    32'(bus.mux_en), 32'h1);
    step(); bus.mux_out = 1'b0;
    step(); bus.mux_out = 1'b1;
    step(); bus.mux_out = 1'b1;
    step();
    chk("t1_valid", 32'(bus.word_valid), 32'h1);
    chk("t1_data",  32'(bus.word_data), 32'h000D);
    chk("t1_ch",    32'(bus.word_ch), 32'h0);
    bus.word_ready = 1'b1;
    step();
    bus.word_ready = 1'b0;

    // round robin from reset
    do_reset();
    order_q.delete();
    bus.req = 16'h8011; bus.burst_len = 4'd1; bus.word_ready = 1'b1;
    got4 = 1'b0;
    for (int n = 0; n < 60; n++) begin
      step();
      bus.mux_out = 1'($urandom_range(0, 1));
      if (order_q.size() >= 4) begin
        got4 = 1'b1;
        break;
      end
    end
    bus.req = '0; bus.word_ready = 1'b0;
    chk("rr_timeout", 32'(got4), 32'h1);
    if (got4) begin
      chk("rr_0", 32'(order_q[0]), 32'd0);
      chk("rr_1", 32'(order_q[1]), 32'd4);
      chk("rr_2", 32'(order_q[2]), 32'd15);
      chk("rr_3", 32'(order_q[3]), 32'd0);
    end
    step();

    // 16-sample burst, then backpressure
    bus.req = 16'h0400; bus.burst_len = 4'd0; bus.mux_out = 1'b1;
    wait_valid(40, 1'b0, en);
    chk("t3_en_cycles", 32'(en), 32'd16);
    chk("t3_data", 32'(bus.word_data), 32'hFFFF);
    chk("t3_ch",   32'(bus.word_ch), 32'd10);
    chk("t3_sel",  32'(bus.mux_sel), 32'hA);
    bus.req = 16'h0003; bus.burst_len = 4'd2;
    repeat (5) step();
    chk("bp_grant", 32'(bus.grant), 32'h0400);
    bus.word_ready = 1'b1;
    step();
    bus.word_ready = 1'b0;
    chk("bp_idle", 32'(bus.busy), 32'h0);
    wait_valid(40, 1'b1, en);
    chk("bp_next_ch", 32'(bus.word_ch), 32'd0);
    bus.req = '0; bus.word_ready = 1'b1;
    step();
    bus.word_ready = 1'b0;
    step();

    // request drop and burst_len change mid-burst
    bus.req = 16'h0020; bus.burst_len = 4'd3;
    step();
    bus.burst_len = 4'd8; bus.mux_out = 1'($urandom_range(0, 1));
    step();
    bus.req = '0; bus.mux_out = 1'($urandom_range(0, 1));
    wait_valid(40, 1'b1, en);
    chk("drop_en_cycles", 32'(en + 2), 32'd3);
    chk("drop_ch", 32'(bus.word_ch), 32'd5);
    bus.word_ready = 1'b1;
    step();
    bus.word_ready = 1'b0;
    step();

    // reset in the middle of a burst
    bus.req = 16'h0001; bus.burst_len = 4'd8;
    step();
    step();
    rst = 1'b1;
    step();
    chk("mrst_busy",  32'(bus.busy), 32'h0);
    chk("mrst_grant", 32'(bus.grant), 32'h0);
    chk("mrst_sel",   32'(bus.mux_sel), 32'h0);
    chk("mrst_data",  32'(bus.word_data), 32'h0);
    rst = 1'b0; bus.req = 16'hFFFF;
    step();
    chk("mrst_first", 32'(bus.grant), 32'h0001);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step();
      bus.req        = 16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535));
      bus.burst_len  = 4'($urandom_range(0, 15));
      bus.mux_out    = 1'($urandom_range(0, 1));
      bus.word_ready = ($urandom_range(0, 2) != 0);
      rst            = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0; bus.req = '0; bus.word_ready = 1'b1;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
